// File: rtl/da_in_feeder.sv
// Input feeder for the DA FIR: buffers bursty samples, streams one per clock,
// appends a zero flush tail per block and tags outputs aligned to the filter.
module da_in_feeder #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned THRESH = 4,
  parameter int unsigned TAPS   = 6,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk_80,
  input  logic              rst_80,
  input  logic              s_valid_80,
  input  logic [DATA_W-1:0] s_data_80,
  input  logic              s_last_80,
  output logic              s_ready_80,
  output logic [DATA_W-1:0] x_in_80,
  output logic              y_valid_80,
  output logic              y_last_80,
  output logic              busy_80,
  output logic              underflow_80
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned FlW  = (TAPS > 2) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   last_cnt_q, last_cnt_d;
  logic [FlW-1:0]    flush_q, flush_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              tag_q, tag_d, tag_last_q, tag_last_d;
  logic              busy_q, underflow_q, underflow_d;
  logic [LAT-1:0]    vpipe_q, lpipe_q;
  logic              push, pop;
  logic [DATA_W:0]   head;

  assign s_ready_80 = (count_q != CntW'(DEPTH));
  assign push       = s_valid_80 && s_ready_80;
  assign pop        = (state_q == StRun) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d    = count_q;
    last_cnt_d = last_cnt_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    if (!push && pop) count_d = count_q - CntW'(1);
    // Tracks buffered block ends so a short block can leave FILL below THRESH.
    if ((push && s_last_80) && !(pop && head[DATA_W])) last_cnt_d = last_cnt_q + CntW'(1);
    if (!(push && s_last_80) && (pop && head[DATA_W])) last_cnt_d = last_cnt_q - CntW'(1);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = '0;
    tag_d       = 1'b0;
    tag_last_d  = 1'b0;
    flush_d     = flush_q;
    underflow_d = underflow_q;
    unique case (state_q)
      StIdle: begin
        if (push) state_d = StFill;
      end
      StFill: begin
        if (count_q >= CntW'(THRESH) || last_cnt_q != '0) state_d = StRun;
      end
      StRun: begin
        if (pop) begin
          x_d   = head[DATA_W-1:0];
          tag_d = 1'b1;
          if (head[DATA_W]) begin
            flush_d = FlW'(TAPS - 1);
            state_d = StFlush;
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
      StFlush: begin
        tag_d   = 1'b1;
        flush_d = flush_q - FlW'(1);
        if (flush_q <= FlW'(1)) begin
          tag_last_d = 1'b1;
          state_d    = (count_d == '0) ? StIdle : StFill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_80) begin
    if (push) mem_q[wr_ptr_q] <= {s_last_80, s_data_80};
  end

  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_cnt_q  <= '0;
      flush_q     <= '0;
      x_q         <= '0;
      tag_q       <= 1'b0;
      tag_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      vpipe_q     <= '0;
      lpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_cnt_q  <= last_cnt_d;
      flush_q     <= flush_d;
      x_q         <= x_d;
      tag_q       <= tag_d;
      tag_last_q  <= tag_last_d;
      busy_q      <= (state_d != StIdle);
      underflow_q <= underflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      vpipe_q[0] <= tag_q;
      lpipe_q[0] <= tag_last_q;
      for (int i = 1; i < int'(LAT); i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end
    end
  end

  assign x_in_80      = x_q;
  assign y_valid_80   = vpipe_q[LAT-1];
  assign y_last_80    = lpipe_q[LAT-1];
  assign busy_80      = busy_q;
  assign underflow_80 = underflow_q;

endmodule

// File: tb/tb_da_in_feeder.sv
// Directed bench for da_in_feeder: three instances (THRESH 1/4/8) share stimulus;
// each scenario task checks the instance it targets against hand-derived values.
module tb_da_in_feeder;

  logic       clk_80 = 1'b0;
  logic       rst_80 = 1'b1;
  logic       s_valid_80 = 1'b0;
  logic [3:0] s_data_80 = 4'h0;
  logic       s_last_80 = 1'b0;

  logic       rdy1, yv1, yl1, busy1, uf1;
  logic [3:0] x1;
  logic       rdy4, yv4, yl4, busy4, uf4;
  logic [3:0] x4;
  logic       rdy8, yv8, yl8, busy8, uf8;
  logic [3:0] x8;

  int checks = 0;
  int failures = 0;

  always #5 clk_80 = ~clk_80;

  da_in_feeder #(.DATA_W(4), .DEPTH(8), .THRESH(1), .TAPS(6), .LAT(2)) u_t1 (
    .clk_80(clk_80), .rst_80(rst_80), .s_valid_80(s_valid_80), .s_data_80(s_data_80),
    .s_last_80(s_last_80), .s_ready_80(rdy1), .x_in_80(x1), .y_valid_80(yv1),
    .y_last_80(yl1), .busy_80(busy1), .underflow_80(uf1)
  );

  da_in_feeder #(.DATA_W(4), .DEPTH(8), .THRESH(4), .TAPS(6), .LAT(2)) u_t4 (
    .clk_80(clk_80), .rst_80(rst_80), .s_valid_80(s_valid_80), .s_data_80(s_data_80),
    .s_last_80(s_last_80), .s_ready_80(rdy4), .x_in_80(x4), .y_valid_80(yv4),
    .y_last_80(yl4), .busy_80(busy4), .underflow_80(uf4)
  );

  da_in_feeder #(.DATA_W(4), .DEPTH(8), .THRESH(8), .TAPS(6), .LAT(2)) u_t8 (
    .clk_80(clk_80), .rst_80(rst_80), .s_valid_80(s_valid_80), .s_data_80(s_data_80),
    .s_last_80(s_last_80), .s_ready_80(rdy8), .x_in_80(x8), .y_valid_80(yv8),
    .y_last_80(yl8), .busy_80(busy8), .underflow_80(uf8)
  );

  task automatic step();
    @(posedge clk_80);
    #1;
  endtask

  task automatic push_one(input logic [3:0] d, input logic l);
    s_valid_80 = 1'b1;
    s_data_80  = d;
    s_last_80  = l;
    step();
    s_valid_80 = 1'b0;
    s_data_80  = 4'h0;
    s_last_80  = 1'b0;
  endtask

  task automatic apply_reset();
    s_valid_80 = 1'b0;
    s_data_80  = 4'h0;
    s_last_80  = 1'b0;
    rst_80 = 1'b1;
    step();
    step();
    rst_80 = 1'b0;
  endtask

  task automatic test_reset();
    // Initial reset state.
    #1;
    checks++;
    if ({x1, yv1, yl1, busy1, uf1, rdy1} !== {4'h0, 5'b00001}) begin
      failures++;
      $display("FAIL reset_init got x=%h yv=%b yl=%b busy=%b uf=%b rdy=%b want 0 0 0 0 0 1",
               x1, yv1, yl1, busy1, uf1, rdy1);
    end
    apply_reset();
    // Five back-to-back pushes into THRESH=4 instance, then two pops -> 3 buffered in RUN.
    s_valid_80 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data_80 = 4'(i + 1);
      step();
    end
    s_valid_80 = 1'b0;
    step();
    step();
    checks++;
    if (x4 !== 4'h2 || busy4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_prerun got x=%h busy=%b want x=2 busy=1", x4, busy4);
    end
    rst_80 = 1'b1;
    #1;
    checks++;
    if ({x4, yv4, yl4, busy4, uf4, rdy4} !== {4'h0, 5'b00001}) begin
      failures++;
      $display("FAIL reset_async got x=%h yv=%b yl=%b busy=%b uf=%b rdy=%b want 0 0 0 0 0 1",
               x4, yv4, yl4, busy4, uf4, rdy4);
    end
    rst_80 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (yv4 !== 1'b0 || yl4 !== 1'b0 || x4 !== 4'h0) begin
        failures++;
        $display("FAIL reset_quiet cycle %0d got yv=%b yl=%b x=%h want 0 0 0", i, yv4, yl4, x4);
      end
    end
  endtask

  task automatic test_impulse();
    logic [3:0] ex;
    logic       ev, el;
    apply_reset();
    push_one(4'h7, 1'b1);
    checks++;
    if (x1 !== 4'h0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL impulse_fill got x=%h busy=%b want x=0 busy=1", x1, busy1);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      ex = (i == 0) ? 4'h7 : 4'h0;
      ev = (i >= 2 && i <= 7);
      el = (i == 7);
      checks++;
      if (x1 !== ex || yv1 !== ev || yl1 !== el) begin
        failures++;
        $display("FAIL impulse cycle %0d got x=%h yv=%b yl=%b want x=%h yv=%b yl=%b",
                 i, x1, yv1, yl1, ex, ev, el);
      end
    end
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL impulse_idle got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_prefill();
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      push_one(4'(s + 1), 1'b0);
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (x4 !== 4'h0 || busy4 !== 1'b1 || yv4 !== 1'b0) begin
          failures++;
          $display("FAIL prefill_hold s=%0d got x=%h busy=%b yv=%b want 0 1 0",
                   s, x4, busy4, yv4);
        end
        step();
      end
    end
    push_one(4'h4, 1'b0);
    step();
    checks++;
    if (x4 !== 4'h0) begin
      failures++;
      $display("FAIL prefill_gap got x=%h want 0", x4);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (x4 !== 4'(i + 1)) begin
        failures++;
        $display("FAIL prefill_stream %0d got x=%h want %h", i, x4, 4'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    s_valid_80 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data_80 = 4'(i + 1);
      checks++;
      if (rdy8 !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept %0d got rdy=%b want 1", i, rdy8);
      end
      step();
    end
    s_data_80 = 4'h9;
    checks++;
    if (rdy8 !== 1'b0 || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got rdy=%b busy=%b want 0 1", rdy8, busy8);
    end
    step();
    checks++;
    if (rdy8 !== 1'b0 || x8 !== 4'h0) begin
      failures++;
      $display("FAIL bp_held got rdy=%b x=%h want 0 0", rdy8, x8);
    end
    step();
    checks++;
    if (rdy8 !== 1'b1 || x8 !== 4'h1) begin
      failures++;
      $display("FAIL bp_reopen got rdy=%b x=%h want 1 1", rdy8, x8);
    end
    step();
    s_valid_80 = 1'b0;
    s_data_80  = 4'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x8 !== 4'(i + 2)) begin
        failures++;
        $display("FAIL bp_stream %0d got x=%h want %h", i, x8, 4'(i + 2));
      end
      step();
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    s_valid_80 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data_80 = 4'(i + 1);
      step();
    end
    s_valid_80 = 1'b0;
    s_data_80  = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (x4 !== 4'(i + 1) || uf4 !== 1'b0) begin
        failures++;
        $display("FAIL uf_stream %0d got x=%h uf=%b want %h 0", i, x4, uf4, 4'(i + 1));
      end
    end
    step();
    checks++;
    if (x4 !== 4'h0 || uf4 !== 1'b1) begin
      failures++;
      $display("FAIL uf_set got x=%h uf=%b want 0 1", x4, uf4);
    end
    step();
    step();
    checks++;
    if (yv4 !== 1'b0 || x4 !== 4'h0 || uf4 !== 1'b1) begin
      failures++;
      $display("FAIL uf_idle got yv=%b x=%h uf=%b want 0 0 1", yv4, x4, uf4);
    end
    push_one(4'h6, 1'b0);
    step();
    checks++;
    if (x4 !== 4'h6 || uf4 !== 1'b1) begin
      failures++;
      $display("FAIL uf_resume got x=%h uf=%b want 6 1", x4, uf4);
    end
    step();
    step();
    checks++;
    if (yv4 !== 1'b1 || uf4 !== 1'b1) begin
      failures++;
      $display("FAIL uf_resume_valid got yv=%b uf=%b want 1 1", yv4, uf4);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ex;
    logic       ev, el;
    int         nlast;
    apply_reset();
    nlast = 0;
    push_one(4'h5, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      s_valid_80 = (i >= 3 && i <= 5);
      s_data_80  = (i >= 3 && i <= 5) ? 4'(i - 2) : 4'h0;
      s_last_80  = (i == 5);
      step();
      ex = (i == 2) ? 4'h5 : (i >= 9 && i <= 11) ? 4'(i - 8) : 4'h0;
      ev = (i >= 4 && i <= 9) || (i >= 11 && i <= 18);
      el = (i == 9) || (i == 18);
      if (yl1 === 1'b1) nlast++;
      checks++;
      if (x1 !== ex || yv1 !== ev || yl1 !== el) begin
        failures++;
        $display("FAIL b2b cycle %0d got x=%h yv=%b yl=%b want x=%h yv=%b yl=%b",
                 i, x1, yv1, yl1, ex, ev, el);
      end
    end
    s_valid_80 = 1'b0;
    s_last_80  = 1'b0;
    checks++;
    if (nlast != 2) begin
      failures++;
      $display("FAIL b2b_last_count got %0d want 2", nlast);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_prefill();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/da_in_feeder.md
# da_in_feeder

Input-side feeder for the distributed-arithmetic FIR (6-tap, 4-bit samples, one sample per clock, no handshake of its own). Accepts bursty 4-bit samples over a valid/ready interface, buffers them in a small FIFO, and drives the filter's sample input every cycle once streaming has started. After the last sample of a block it injects zero flush samples to drain the filter tail. It also emits a valid/last tag pipeline aligned to the filter output register, so downstream logic can tell real outputs from idle ones.

## Interface
- DATA_W, 4, sample width; matches the filter's `x_in_80` input.
- DEPTH, 8, FIFO entries; power of two, at least 4.
- THRESH, 4, FIFO occupancy needed to leave FILL; 1 ≤ THRESH ≤ DEPTH.
- TAPS, 6, filter taps; the flush injects TAPS-1 zeros.
- LAT, 2, cycles from `x_in_80` presented to the matching `y_out_80` in the filter.

Ports:
- clk_80  in  1  clock; all state updates on the rising edge.
- rst_80  in  1  reset, asynchronous, active-high.
- s_valid_80  in  1  upstream sample valid.
- s_data_80  in  DATA_W  upstream sample (two's complement).
- s_last_80  in  1  marks the final sample of a block; qualified by s_valid_80.
- s_ready_80  out  1  feeder can accept a sample.
- x_in_80  out  DATA_W  registered sample to the filter.
- y_valid_80  out  1  the filter output in this cycle corresponds to a real or flush sample.
- y_last_80  out  1  the filter output in this cycle is the final output of the block.
- busy_80  out  1  state is not IDLE.
- underflow_80  out  1  sticky; FIFO was empty during RUN before the last sample.

## Operation
- **FIFO**
  - Each entry holds {last, data}.
  - Push when s_valid_80 && s_ready_80.
  - s_ready_80 = !full. It does not depend on a same-cycle pop.
  - Occupancy counter is clog2(DEPTH+1) bits.
  - Simultaneous push and pop leaves the count unchanged.
- **FSM states:** IDLE, FILL, RUN, FLUSH.
- **IDLE**
  - x_in_80 = 0, tag = 0.
  - Go to FILL on the first accepted push.
- **FILL**
  - No pops; x_in_80 = 0, tag = 0.
  - Go to RUN when count ≥ THRESH, or when any buffered entry has last = 1.
- **RUN**
  - Pop one entry per cycle.
  - Register x_in_80 ← entry data, tag ← 1.
  - If the FIFO is empty: x_in_80 ← 0, tag ← 0, set underflow_80, stay in RUN.
  - When the popped entry has last = 1: load the flush counter with TAPS-1 and go to FLUSH.
- **FLUSH**
  - x_in_80 ← 0, tag ← 1, decrement the counter once per cycle.
  - On the cycle the counter goes 1→0, assert tag_last.
  - Then go to IDLE if the FIFO is empty, else to FILL.
  - Pushes are accepted throughout FLUSH.
- **Tag pipeline**
  - {tag, tag_last} are registered alongside x_in_80.
  - They are delayed by LAT further registers to give y_valid_80 and y_last_80.
- **underflow_80** clears only on reset.
- **Sign handling:** none. Data passes through unchanged.

## Timing
- All outputs except s_ready_80 are registered.
- Reset values: x_in_80 = 0, y_valid_80 = 0, y_last_80 = 0, busy_80 = 0, underflow_80 = 0, s_ready_80 = 1, FIFO empty, state IDLE.
- **Push to x_in_80, THRESH = 1:**
  - Edge k accepts the push (IDLE→FILL).
  - Edge k+1: FILL→RUN.
  - Edge k+2: pop; x_in_80 is valid from cycle k+2.
- **Sample to output:** a sample on x_in_80 in cycle c has its y_valid_80 asserted in cycle c+LAT, aligned with the filter's y_out_80.
- **Block tail:**
  - The last data sample is followed by exactly TAPS-1 consecutive zero samples with tag = 1.
  - y_last_80 pulses for one cycle, on the final flush output.
- **Full FIFO:** s_ready_80 drops the cycle after the push that fills it, and rises the cycle after the next pop.
- **s_last_80 handling:** a block of a single sample with s_last_80 = 1 goes directly FILL→RUN→FLUSH.
- **Reset mid-operation:**
  - The FIFO, tag pipeline and FSM clear asynchronously.
  - No y_valid_80 or y_last_80 pulse is generated for discarded samples.

## Test plan
- **Reset:** assert rst_80 mid-RUN with 3 samples buffered → all outputs go to their reset values in the same cycle; after release, y_valid_80 stays 0 for 10 cycles.
- **Impulse block:** with THRESH = 1, push 4'h7 (last = 1) → x_in_80 = 7, 0, 0, 0, 0, 0 in consecutive cycles. y_valid_80 is high for 6 cycles starting 2 cycles after the 7, and y_last_80 is high on the 6th.
- **Prefill:** with THRESH = 4, push 3 samples spaced by idle cycles → no pops and busy_80 = 1. The 4th push → RUN starts and 4 samples stream back-to-back.
- **Backpressure:** hold s_valid_80 high with the FSM held in FILL (THRESH = 8, DEPTH = 8) → s_ready_80 = 0 after 8 accepts, and the 9th sample is held upstream until RUN starts.
- **Underflow:** push 5 samples then stall upstream without last → after the 5 pops, x_in_80 = 0, y_valid_80 = 0 and underflow_80 = 1. A resumed push is streamed and underflow_80 stays 1.
- **Back-to-back blocks:** push block A (3 samples, last) during block B's flush → A's first sample appears only after the 5 flush zeros, and y_last_80 pulses once per block.
